// File: rtl/pc_unit.sv
// Program counter with load (jump), halt/resume control and a one-cycle wrap pulse.
// Optional build macro PC_UNIT_STEP_EN adds a 'step' input for single-stepping in HALT.
module pc_unit #(
  parameter int unsigned             WIDTH     = 8,
  parameter logic [WIDTH-1:0]        RESET_VEC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_en,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             halt,
  input  logic             resume,
`ifdef PC_UNIT_STEP_EN
  input  logic             step,
`endif
  output logic [WIDTH-1:0] pc,
  output logic             running,
  output logic             wrap
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] pc_nxt;
  logic             wrap_nxt;
  logic [WIDTH:0]   pc_inc;

  // Carry out of the MSB lands in bit WIDTH and becomes the wrap flag.
  function automatic logic [WIDTH:0] incr(input logic [WIDTH-1:0] v);
    incr = {1'b0, v} + {{WIDTH{1'b0}}, 1'b1};
  endfunction

  assign pc_inc = incr(pc);

  // Next-state, next-pc and wrap decode; first matching request wins.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    wrap_nxt  = 1'b0;
    case (state)
      ST_RUN: begin
        if (ld) begin
          pc_nxt = ld_val;
        end else if (halt) begin
          state_nxt = ST_HALT;
        end else if (inc_en) begin
          pc_nxt   = pc_inc[WIDTH-1:0];
          wrap_nxt = pc_inc[WIDTH];
        end else begin
          pc_nxt = pc;
        end
      end
      ST_HALT: begin
        if (ld) begin
          pc_nxt = ld_val;
          if (resume) begin
            state_nxt = ST_RUN;
          end else begin
            state_nxt = ST_HALT;
          end
        end else if (resume) begin
          state_nxt = ST_RUN;
`ifdef PC_UNIT_STEP_EN
        end else if (step) begin
          pc_nxt   = pc_inc[WIDTH-1:0];
          wrap_nxt = pc_inc[WIDTH];
`endif
        end else begin
          state_nxt = ST_HALT;
        end
      end
      default: begin
        state_nxt = ST_RUN;
        pc_nxt    = RESET_VEC;
      end
    endcase
  end

  // State and output registers; running is registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_RUN;
      pc      <= RESET_VEC;
      running <= 1'b1;
      wrap    <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      running <= (state_nxt == ST_RUN);
      wrap    <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a reference model pushes expected {pc,running,wrap}
// per cycle, which is popped and compared one edge later.
module tb_pc_unit;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       inc_en = 1'b0;
  logic       ld = 1'b0;
  logic [7:0] ld_val = 8'h00;
  logic       halt = 1'b0;
  logic       resume = 1'b0;
  logic       step = 1'b0;
  logic [7:0] pc;
  logic       running;
  logic       wrap;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] m_pc = 8'h00;
  logic       m_run = 1'b1;
  logic       m_wrap = 1'b0;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  pc_unit #(.WIDTH(8), .RESET_VEC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .inc_en(inc_en), .ld(ld), .ld_val(ld_val),
    .halt(halt), .resume(resume),
`ifdef PC_UNIT_STEP_EN
    .step(step),
`endif
    .pc(pc), .running(running), .wrap(wrap)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference model: one rising edge.
  task automatic model_edge(input logic r, i, l, input logic [7:0] lv, input logic h, rs, st);
    logic step_ok;
`ifdef PC_UNIT_STEP_EN
    step_ok = 1'b1;
`else
    step_ok = 1'b0;
`endif
    m_wrap = 1'b0;
    if (!r) begin
      m_pc = 8'h00; m_run = 1'b1;
    end else if (m_run) begin
      if (l) m_pc = lv;
      else if (h) m_run = 1'b0;
      else if (i) begin
        m_wrap = (m_pc == 8'hFF);
        m_pc = m_pc + 8'd1;
      end
    end else begin
      if (l) begin
        m_pc = lv;
        if (rs) m_run = 1'b1;
      end else if (rs) m_run = 1'b1;
      else if (st && step_ok) begin
        m_wrap = (m_pc == 8'hFF);
        m_pc = m_pc + 8'd1;
      end
    end
  endtask

  task automatic cyc(input string tag, input logic r, i, l, input logic [7:0] lv,
                     input logic h, rs, st);
    logic [9:0] e;
    @(negedge clk);
    rst_n = r; inc_en = i; ld = l; ld_val = lv; halt = h; resume = rs; step = st;
    model_edge(r, i, l, lv, h, rs, st);
    exp_q.push_back({m_pc, m_run, m_wrap});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 16'd1, 16'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, {6'd0, pc, running, wrap}, {6'd0, e});
    end
  endtask

  initial begin
    // Reset held for two edges, then free-run.
    cyc("rst", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc("rst", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("rst_pc", {8'd0, pc}, 16'h0000);
    check("rst_run", {15'd0, running}, 16'd1);
    check("rst_wrap", {15'd0, wrap}, 16'd0);
    for (int k = 0; k < 5; k++) cyc("free", 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("free5", {8'd0, pc}, 16'h0005);

    // Wrap FE -> FF -> 00 -> 01.
    cyc("ld_fe", 1'b1, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
    cyc("to_ff", 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("ff_nowrap", {15'd0, wrap}, 16'd0);
    cyc("to_00", 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("wrap_00", {7'd0, pc, wrap}, {7'd0, 8'h00, 1'b1});
    cyc("to_01", 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("wrap_clr", {7'd0, pc, wrap}, {7'd0, 8'h01, 1'b0});
    cyc("ld_0", 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    check("ld0_nowrap", {15'd0, wrap}, 16'd0);

    // Halt / resume at pc=10.
    cyc("ld_10", 1'b1, 1'b1, 1'b1, 8'd10, 1'b0, 1'b0, 1'b0);
    cyc("halt", 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("halt_st", {7'd0, pc, running}, {7'd0, 8'd10, 1'b0});
    for (int k = 0; k < 3; k++) cyc("idle", 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc("resume", 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("resume_st", {7'd0, pc, running}, {7'd0, 8'd10, 1'b1});
    cyc("post_res", 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("post_res_pc", {8'd0, pc}, {8'd0, 8'd11});

    // Load priority over halt in RUN, and ld+resume in HALT.
    cyc("ld_20", 1'b1, 1'b1, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
    cyc("ld_halt", 1'b1, 1'b1, 1'b1, 8'h40, 1'b1, 1'b0, 1'b0);
    check("ld_over_halt", {7'd0, pc, running}, {7'd0, 8'h40, 1'b1});
    cyc("halt2", 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cyc("ld_in_halt", 1'b1, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    check("ld_hold_halt", {7'd0, pc, running}, {7'd0, 8'h55, 1'b0});
    cyc("ld_res", 1'b1, 1'b1, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0);
    check("ld_resume", {7'd0, pc, running}, {7'd0, 8'h80, 1'b1});

    // Reset in HALT.
    cyc("ld_33", 1'b1, 1'b1, 1'b1, 8'd33, 1'b0, 1'b0, 1'b0);
    cyc("halt3", 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cyc("rst_h", 1'b0, 1'b1, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    check("rst_halt", {6'd0, pc, running, wrap}, {6'd0, 8'h00, 1'b1, 1'b0});
    cyc("after_rst", 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("after_rst_pc", {8'd0, pc}, 16'h0001);

    // Step in HALT (increments only when the feature is built in).
    cyc("ld_7", 1'b1, 1'b1, 1'b1, 8'd7, 1'b0, 1'b0, 1'b0);
    cyc("halt4", 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cyc("step1", 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc("step2", 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
`ifdef PC_UNIT_STEP_EN
    check("step_pc", {7'd0, pc, running}, {7'd0, 8'd9, 1'b0});
`else
    check("nostep_pc", {7'd0, pc, running}, {7'd0, 8'd7, 1'b0});
`endif
    cyc("step_ld", 1'b1, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1);
    check("step_ld_pc", {8'd0, pc}, 16'h0002);
    cyc("ld_ff", 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    cyc("step_wrap", 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Random traffic against the model.
    for (int k = 0; k < 300; k++) begin
      cyc("rand", ($urandom_range(0, 19) != 0), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 5) == 0), 8'($urandom_range(0, 255)),
          ($urandom_range(0, 6) == 0), ($urandom_range(0, 4) == 0),
          1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
